// File: rtl/sevenseg_scan_reader_if.sv
// Bus bundle for the 7-segment scan reader.
//   seg/dig_en   : multiplexed display bus being observed
//   out_*        : frame hand-off (valid/ready) with per-slot illegal flags
//   err/err_clr  : sticky error flag and its synchronous clear
// slave is the reader side; master is the display/consumer side.
interface sevenseg_scan_reader_if #(
  parameter int unsigned NDIG = 4
);
  logic [6:0]        seg;
  logic [NDIG-1:0]   dig_en;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_digits;
  logic [NDIG-1:0]   out_bad;
  logic              err;
  logic              err_clr;

  modport slave (
    input  seg, dig_en, out_ready, err_clr,
    output out_valid, out_digits, out_bad, err
  );

  modport master (
    output seg, dig_en, out_ready, err_clr,
    input  out_valid, out_digits, out_bad, err
  );
endinterface

// File: rtl/sevenseg_scan_reader.sv
// Recovers BCD digits from a multiplexed 7-segment display bus.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - sevenseg_scan_reader_if.slave (seg/dig_en in, frame out,
//            sticky err with err_clr)
// Each {seg,dig_en} pattern must be seen STABLE_CYCLES consecutive samples
// before it is captured into its slot; when every slot has been filled the
// slots are handed off as one frame over valid/ready.
module sevenseg_scan_reader #(
  parameter int unsigned NDIG          = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sevenseg_scan_reader_if.slave bus
);

  localparam int unsigned SW = NDIG + 7;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    CHANGING,
    COUNTING,
    CAPTURED
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       sample_q, sample_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*NDIG-1:0]   slot_q, slot_d;
  logic [NDIG-1:0]     bad_q, bad_d;
  logic [NDIG-1:0]     filled_q, filled_d;
  logic                out_valid_q, out_valid_d;
  logic [4*NDIG-1:0]   out_digits_q, out_digits_d;
  logic [NDIG-1:0]     out_bad_q, out_bad_d;
  logic                err_q, err_d;

  logic                same;
  logic                capture;
  logic                load;
  logic                err_event;
  logic [6:0]          cap_seg;
  logic [NDIG-1:0]     cap_en;
  logic [4:0]          cap_dec;

  // Returns {legal, digit}; illegal patterns yield digit 4'hF.
  function automatic logic [4:0] dec7(input logic [6:0] s);
    case (s)
      7'h3F:   dec7 = {1'b1, 4'd0};
      7'h06:   dec7 = {1'b1, 4'd1};
      7'h5B:   dec7 = {1'b1, 4'd2};
      7'h4F:   dec7 = {1'b1, 4'd3};
      7'h66:   dec7 = {1'b1, 4'd4};
      7'h6D:   dec7 = {1'b1, 4'd5};
      7'h7D:   dec7 = {1'b1, 4'd6};
      7'h07:   dec7 = {1'b1, 4'd7};
      7'h7F:   dec7 = {1'b1, 4'd8};
      7'h6F:   dec7 = {1'b1, 4'd9};
      default: dec7 = {1'b0, 4'hF};
    endcase
  endfunction

  // Stability filter and capture FSM
  always_comb begin
    sample_d = {bus.seg, bus.dig_en};
    same     = (sample_d == sample_q);
    capture  = 1'b0;
    state_d  = state_q;

    if (!same)
      cnt_d = CW'(1);
    else if (cnt_q == CW'(STABLE_CYCLES))
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CW'(1);

    case (state_q)
      CHANGING, COUNTING: begin
        if (!same) begin
          state_d = COUNTING;
        end else if (cnt_d == CW'(STABLE_CYCLES)) begin
          // Fires on the edge the counter reaches the threshold, so a
          // pattern held from edge E is captured at E+STABLE_CYCLES-1.
          capture = 1'b1;
          state_d = CAPTURED;
        end else begin
          state_d = COUNTING;
        end
      end
      CAPTURED: begin
        if (!same) state_d = COUNTING;
      end
      default: state_d = CHANGING;
    endcase
  end

  // Slot update, frame load and error tracking
  always_comb begin
    cap_seg      = sample_q[NDIG +: 7];
    cap_en       = sample_q[NDIG-1:0];
    cap_dec      = dec7(cap_seg);
    slot_d       = slot_q;
    bad_d        = bad_q;
    filled_d     = filled_q;
    out_valid_d  = out_valid_q;
    out_digits_d = out_digits_q;
    out_bad_d    = out_bad_q;
    err_event    = 1'b0;

    load = (&filled_q) && (!out_valid_q || bus.out_ready);

    if (load) begin
      out_digits_d = slot_q;
      out_bad_d    = bad_q;
      out_valid_d  = 1'b1;
      filled_d     = '0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Applied after the load clear so a same-edge capture keeps its filled bit.
    if (capture && (cap_en != '0)) begin
      if ($onehot(cap_en)) begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (cap_en[i]) begin
            slot_d[4*i +: 4] = cap_dec[3:0];
            bad_d[i]         = ~cap_dec[4];
            filled_d[i]      = 1'b1;
            err_event        = ~cap_dec[4];
          end
        end
      end else begin
        err_event = 1'b1;
      end
    end

    err_d = (err_q & ~bus.err_clr) | err_event;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CHANGING;
      sample_q     <= '0;
      cnt_q        <= '0;
      slot_q       <= '0;
      bad_q        <= '0;
      filled_q     <= '0;
      out_valid_q  <= 1'b0;
      out_digits_q <= '0;
      out_bad_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      bad_q        <= bad_d;
      filled_q     <= filled_d;
      out_valid_q  <= out_valid_d;
      out_digits_q <= out_digits_d;
      out_bad_q    <= out_bad_d;
      err_q        <= err_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_digits = out_digits_q;
  assign bus.out_bad    = out_bad_q;
  assign bus.err        = err_q;

endmodule

// File: doc/sevenseg_scan_reader.md
Name: sevenseg_scan_reader

Overview:
- Reads a multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and recovers the BCD digit shown on each position.
- The inverse of the team's 7-segment decoder. Used for display loopback checking and for capturing front-panel readouts.
- Filters scan transitions with a stability counter and decodes each stable pattern to 0-9, flagging illegal patterns.
- Hands off complete multi-digit frames over a valid/ready interface.

Parameters:
- NDIG, 4, number of digit positions (one-hot enables); legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, active-high; seg[0]=a .. seg[6]=g.
- dig_en  input  NDIG  digit enables, active-high, one-hot expected.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame.
- out_digits  output  4*NDIG  digit i in bits [4i+3:4i].
- out_bad  output  NDIG  bit i set means slot i held an illegal pattern.
- err  output  1  sticky error flag.
- err_clr  input  1  synchronous clear of err.

Behaviour:
- Reset (async, rst_n=0) clears immediately: out_valid=0, out_digits=0, out_bad=0, err=0, sample register=0, stability counter=0, all slot values and filled bits=0. Reset mid-frame discards partial slots and any pending output.
- Sampling: {seg,dig_en} is registered every edge into sample_q.
  - If the new sample equals sample_q, the counter increments and saturates at STABLE_CYCLES.
  - Otherwise the counter loads 1.
- Capture FSM has three states: CHANGING, COUNTING, CAPTURED.
  - A capture event fires once, on the edge where the counter reaches STABLE_CYCLES. Timing: input applied before edge E and held unchanged gives a slot write at edge E+STABLE_CYCLES-1.
  - No further capture occurs until the sample changes (CAPTURED returns to COUNTING).
- Decode table, seg as hex g..a: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9. Any other value is illegal.
- On a capture event:
  - dig_en all-zero (blanking interval): ignored, no error.
  - dig_en one-hot at bit i, legal pattern: slot i value = decoded digit, bad[i]=0, filled[i]=1.
  - dig_en one-hot at bit i, illegal pattern: slot i value = 4'hF, bad[i]=1, filled[i]=1, err set.
  - dig_en with more than one bit set: ignored, err set.
  - A recapture of an already-filled slot overwrites it with the latest value.
- Frame load happens when all filled bits are set and (out_valid==0 or out_ready==1). On that edge:
  - out_digits and out_bad load from the slots, out_valid goes to 1.
  - All filled bits clear. If a capture lands on that same edge, its slot is written and that filled bit stays set.
- Handshake:
  - out_digits and out_bad are stable while out_valid=1 and out_ready=0.
  - A transfer occurs on an edge with out_valid & out_ready; out_valid falls unless a new frame loads on the same edge (back-to-back allowed).
  - out_valid never depends combinationally on out_ready.
- err is sticky. err_clr clears it, but an error event on the same edge wins and err stays 1.

Test Plan:
- Digits 1,2,3,4 (seg 0x06,0x5B,0x4F,0x66) on dig_en 0001,0010,0100,1000, each held 6 cycles, out_ready=1 -> out_valid pulses, out_digits=16'h4321, out_bad=0, err=0.
- Each of the ten legal patterns on slot 0 with NDIG=1 -> out_digits equals the digit 0..9 in order; pattern held only STABLE_CYCLES-1 cycles before changing -> no capture, no out_valid.
- Slot 2 shows seg=0x00 within an otherwise valid 5,6,X,8 scan -> out_digits=16'h8F65, out_bad=4'b0100, err=1.
- dig_en=0011 held 6 cycles -> no slot written, err=1; err_clr=1 for one cycle -> err=0; err_clr together with a new error event -> err stays 1.
- out_ready=0 while frames 16'h1111 then 16'h2222 complete -> output holds 1111; raise out_ready -> 1111 transfers and 2222 loads on the same edge, out_valid stays 1.
- rst_n pulsed low after two of four slots are captured -> out_valid=0 immediately; after release a full scan of 9,9,9,9 produces exactly one frame 16'h9999.
